// File: rtl/quartsine_dds_pwm.sv
// Multi-channel quarter-wave sine DDS: per-channel phase accumulators share one external
// quarter ROM, the channel samples are averaged and emitted as fixed-period PWM.
//   state     | meaning
//   S_IDLE    | waiting for the next PWM period start
//   S_ISSUE   | drive the mirrored quarter-ROM address for channel ch_q
//   S_WAIT    | ROM samples the address
//   S_CAPTURE | fold the (possibly negated) ROM word of channel ch_q into acc
//   S_DONE    | average acc into the pending level, back to idle
module quartsine_dds_pwm #(
  parameter int NCH     = 2,
  parameter int PHASE_W = 24,
  parameter int LUT_AW  = 8,
  parameter int AMP_W   = 11
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   en,
  input  logic [NCH*PHASE_W-1:0] tuning_word,
  input  logic                   tw_load,
  input  logic [NCH-1:0]         ch_enable,
  output logic [LUT_AW-1:0]      lut_addr,
  input  logic [AMP_W-2:0]       lut_data,
  output logic                   AUD_PWM,
  output logic                   AUD_SD,
  output logic [AMP_W-1:0]       magnitude,
  output logic                   phasesw,
  output logic                   invert,
  output logic                   sample_strobe
);
  localparam int SH    = $clog2(NCH);
  localparam int CH_W  = (NCH > 1) ? SH : 1;
  localparam int ACC_W = AMP_W + SH;
  localparam logic [AMP_W-1:0] MID = {1'b1, {(AMP_W-1){1'b0}}};

  if (3 * NCH + 2 >= 2 ** AMP_W) begin : g_seq_len_err
    $error("quartsine_dds_pwm: channel sequence does not fit in one PWM period");
  end
  if ((NCH < 1) || ((NCH & (NCH - 1)) != 0)) begin : g_nch_err
    $error("quartsine_dds_pwm: NCH must be a power of two");
  end
  if (PHASE_W - 2 < LUT_AW) begin : g_lut_err
    $error("quartsine_dds_pwm: LUT_AW too wide for PHASE_W");
  end

  typedef enum logic [2:0] {S_IDLE, S_ISSUE, S_WAIT, S_CAPTURE, S_DONE} state_e;

  state_e                  state_q, state_d;
  logic [CH_W-1:0]         ch_q, ch_d;
  logic [PHASE_W-1:0]      phase_q [NCH];
  logic [PHASE_W-1:0]      phase_d [NCH];
  logic [PHASE_W-1:0]      step_q  [NCH];
  logic [PHASE_W-1:0]      step_d  [NCH];
  logic [AMP_W-1:0]        pwm_cnt_q, pwm_cnt_d;
  logic [AMP_W-1:0]        level_q, level_d;
  logic [AMP_W-1:0]        pending_q, pending_d;
  logic signed [ACC_W-1:0] acc_q, acc_d;
  logic [LUT_AW-1:0]       lut_addr_q, lut_addr_d;
  logic                    pwm_q, pwm_d;
  logic                    sd_q, sd_d;
  logic                    strobe_q, strobe_d;

  logic                    period_start;
  logic                    mirror_bit, negate_bit;
  logic [LUT_AW-1:0]       raw_idx, cur_addr;
  logic [AMP_W-1:0]        rom_mag;
  logic signed [AMP_W-1:0] cur_sample;

  assign period_start = en && (pwm_cnt_q == '0);
  assign mirror_bit   = phase_q[ch_q][PHASE_W-2];
  assign negate_bit   = phase_q[ch_q][PHASE_W-1];
  assign raw_idx      = phase_q[ch_q][PHASE_W-3 -: LUT_AW];
  assign cur_addr     = mirror_bit ? ~raw_idx : raw_idx;
  assign rom_mag      = {1'b0, lut_data};
  assign cur_sample   = !ch_enable[ch_q] ? '0 : (negate_bit ? -rom_mag : rom_mag);

  always_comb begin
    state_d    = state_q;
    ch_d       = ch_q;
    phase_d    = phase_q;
    step_d     = step_q;
    pending_d  = pending_q;
    acc_d      = acc_q;
    lut_addr_d = lut_addr_q;
    pwm_cnt_d  = en ? pwm_cnt_q + 1'b1 : '0;
    level_d    = period_start ? pending_q : level_q;
    // compare against the level that is live for this period, so the duty is exact
    pwm_d      = en && (pwm_cnt_q < level_d);
    sd_d       = en;
    strobe_d   = period_start;

    if (tw_load) begin
      for (int i = 0; i < NCH; i++) begin
        step_d[i] = tuning_word[i*PHASE_W +: PHASE_W];
      end
    end

    case (state_q)
      S_ISSUE: begin
        lut_addr_d = cur_addr;
        state_d    = S_WAIT;
      end
      S_WAIT: state_d = S_CAPTURE;
      S_CAPTURE: begin
        acc_d = acc_q + ACC_W'(cur_sample);
        if (ch_q == CH_W'(NCH - 1)) begin
          state_d = S_DONE;
        end else begin
          ch_d    = ch_q + 1'b1;
          state_d = S_ISSUE;
        end
      end
      S_DONE: begin
        pending_d = AMP_W'(acc_q >>> SH) + MID;
        state_d   = S_IDLE;
      end
      default: ;
    endcase

    if (period_start) begin
      for (int i = 0; i < NCH; i++) begin
        phase_d[i] = ch_enable[i] ? phase_q[i] + step_q[i] : '0;
      end
      ch_d    = '0;
      acc_d   = '0;
      state_d = S_ISSUE;
    end

    if (!en) begin
      state_d = S_IDLE;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      ch_q       <= '0;
      phase_q    <= '{default: '0};
      step_q     <= '{default: '0};
      pwm_cnt_q  <= '0;
      level_q    <= MID;
      pending_q  <= MID;
      acc_q      <= '0;
      lut_addr_q <= '0;
      pwm_q      <= 1'b0;
      sd_q       <= 1'b0;
      strobe_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      ch_q       <= ch_d;
      phase_q    <= phase_d;
      step_q     <= step_d;
      pwm_cnt_q  <= pwm_cnt_d;
      level_q    <= level_d;
      pending_q  <= pending_d;
      acc_q      <= acc_d;
      lut_addr_q <= lut_addr_d;
      pwm_q      <= pwm_d;
      sd_q       <= sd_d;
      strobe_q   <= strobe_d;
    end
  end

  assign lut_addr      = lut_addr_q;
  assign AUD_PWM       = pwm_q;
  assign AUD_SD        = sd_q;
  assign magnitude     = level_q;
  assign phasesw       = phase_q[0][PHASE_W-2];
  assign invert        = phase_q[0][PHASE_W-1];
  assign sample_strobe = strobe_q;

endmodule

// File: tb/tb_quartsine_dds_pwm.sv
// Scoreboard bench for quartsine_dds_pwm: a per-period arithmetic model pushes the
// expected level/flags, a monitor pops them on every sample_strobe.
module tb_quartsine_dds_pwm;
  localparam int NCH     = 2;
  localparam int PHASE_W = 24;
  localparam int LUT_AW  = 8;
  localparam int AMP_W   = 11;
  localparam int TW_W    = NCH * PHASE_W;
  localparam int PERIOD  = 1 << AMP_W;
  localparam int MIDV    = 1 << (AMP_W - 1);
  localparam longint PMASK = (longint'(1) << PHASE_W) - 1;

  logic                clk = 1'b0;
  logic                rst_n = 1'b0;
  logic                en = 1'b0;
  logic                tw_load = 1'b0;
  logic [TW_W-1:0]     tuning_word = '0;
  logic [NCH-1:0]      ch_enable = '0;
  logic [LUT_AW-1:0]   lut_addr;
  logic [AMP_W-2:0]    lut_data;
  logic                AUD_PWM, AUD_SD, phasesw, invert, sample_strobe;
  logic [AMP_W-1:0]    magnitude;

  int checks = 0;
  int failures = 0;

  quartsine_dds_pwm #(.NCH(NCH), .PHASE_W(PHASE_W), .LUT_AW(LUT_AW), .AMP_W(AMP_W)) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .tuning_word(tuning_word), .tw_load(tw_load),
    .ch_enable(ch_enable), .lut_addr(lut_addr), .lut_data(lut_data), .AUD_PWM(AUD_PWM),
    .AUD_SD(AUD_SD), .magnitude(magnitude), .phasesw(phasesw), .invert(invert),
    .sample_strobe(sample_strobe)
  );

  always #5 clk = ~clk;

  // quarter ROM stand-in: data = address, one clock of read latency
  always @(posedge clk) lut_data <= (AMP_W-1)'(lut_addr);

  typedef struct {
    int level;
    int sw;
    int inv;
    int addr0;
  } exp_t;

  exp_t   exp_q[$];
  longint m_phase [NCH];
  longint m_step  [NCH];
  int     m_pending;

  task automatic check(input string name, input longint act, input longint req);
    checks++;
    if (act != req) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d at %0t", name, act, req, $time);
    end
  endtask

  function automatic int quad_of(input longint ph);
    return int'((ph >> (PHASE_W - 2)) & 3);
  endfunction

  function automatic int addr_of(input longint ph);
    int idx = int'((ph >> (PHASE_W - 2 - LUT_AW)) & ((1 << LUT_AW) - 1));
    if ((quad_of(ph) & 1) != 0) idx = (1 << LUT_AW) - 1 - idx;
    return idx;
  endfunction

  // sine sample in quarter-table units: mirrored in quadrants 1/3, negated in 2/3
  function automatic int sine_of(input longint ph);
    int v = addr_of(ph);
    return ((quad_of(ph) & 2) != 0) ? -v : v;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < NCH; i++) begin
      m_phase[i] = 0;
      m_step[i]  = 0;
    end
    m_pending = MIDV;
  endtask

  // one PWM period start: emit old pending, advance phases, compute the next level
  task automatic model_period();
    exp_t e;
    int sum, avg;
    e.level = m_pending;
    for (int i = 0; i < NCH; i++) begin
      m_phase[i] = ch_enable[i] ? ((m_phase[i] + m_step[i]) & PMASK) : 0;
    end
    e.sw    = quad_of(m_phase[0]) & 1;
    e.inv   = (quad_of(m_phase[0]) >> 1) & 1;
    e.addr0 = addr_of(m_phase[0]);
    sum = 0;
    for (int i = 0; i < NCH; i++) begin
      if (ch_enable[i]) sum += sine_of(m_phase[i]);
    end
    avg = (sum >= 0) ? sum / NCH : -((-sum + NCH - 1) / NCH);
    m_pending = (((avg + MIDV) % PERIOD) + PERIOD) % PERIOD;
    exp_q.push_back(e);
  endtask

  task automatic wait_strobe();
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!sample_strobe && n < 3 * PERIOD);
    check("strobe_arrival", longint'(sample_strobe), 1);
  endtask

  task automatic run_periods(input int k);
    repeat (k) begin
      model_period();
      wait_strobe();
    end
  endtask

  task automatic load_tw(input logic [TW_W-1:0] tw);
    tuning_word = tw;
    tw_load = 1'b1;
    for (int i = 0; i < NCH; i++) m_step[i] = longint'(tw[i*PHASE_W +: PHASE_W]);
    @(negedge clk);
    tw_load = 1'b0;
  endtask

  task automatic settle();
    repeat (20) @(negedge clk);
  endtask

  // monitor state
  exp_t me;
  int   win_ok = 0, win_len = 0, win_hi = 0, win_lvl = 0;
  int   addr_pend = 0, addr_exp = 0;

  initial begin : monitor
    forever begin
      @(negedge clk);
      if (!AUD_SD) begin
        win_ok    = 0;
        addr_pend = 0;
      end else begin
        if (addr_pend != 0) begin
          check("lut_addr_ch0", longint'(lut_addr), addr_exp);
          addr_pend = 0;
        end
        if (sample_strobe) begin
          if (win_ok != 0) begin
            check("strobe_period", win_len, PERIOD);
            check("pwm_high_count", win_hi, win_lvl);
          end
          if (exp_q.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL unexpected_strobe actual=strobe required=none at %0t", $time);
            win_ok = 0;
          end else begin
            me = exp_q.pop_front();
            check("magnitude", longint'(magnitude), me.level);
            check("phasesw", longint'(phasesw), me.sw);
            check("invert", longint'(invert), me.inv);
            addr_exp  = me.addr0;
            addr_pend = 1;
            win_ok    = 1;
            win_lvl   = me.level;
            win_len   = 0;
            win_hi    = 0;
          end
        end
        if (win_ok != 0) begin
          win_len++;
          win_hi += int'(AUD_PWM);
        end
      end
    end
  end

  initial begin : watchdog
    #1200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin : driver
    logic [TW_W-1:0] rtw;
    model_reset();
    #12;
    check("rst_aud_pwm", longint'(AUD_PWM), 0);
    check("rst_aud_sd", longint'(AUD_SD), 0);
    check("rst_magnitude", longint'(magnitude), MIDV);
    check("rst_lut_addr", longint'(lut_addr), 0);
    check("rst_strobe", longint'(sample_strobe), 0);
    check("rst_phasesw", longint'(phasesw), 0);
    check("rst_invert", longint'(invert), 0);
    @(negedge clk);
    rst_n = 1'b1;

    // single channel, quarter-cycle step
    ch_enable = 2'b01;
    load_tw({24'd0, 24'h400000});
    en = 1'b1;
    run_periods(5);

    // both channels at the same step
    settle();
    ch_enable = 2'b11;
    load_tw({24'h400000, 24'h400000});
    run_periods(4);

    // drop en mid-period and resume
    repeat (1000) @(negedge clk);
    en = 1'b0;
    repeat (5) begin
      repeat (1000) @(negedge clk);
      check("en_low_aud_pwm", longint'(AUD_PWM), 0);
      check("en_low_aud_sd", longint'(AUD_SD), 0);
    end
    en = 1'b1;
    run_periods(4);

    // step reload on the period-start cycle: old step used once
    model_period();
    m_step[0] = 64'h200000;
    repeat (PERIOD - 1) @(negedge clk);
    tuning_word = {24'h400000, 24'h200000};
    tw_load = 1'b1;
    wait_strobe();
    tw_load = 1'b0;
    run_periods(3);

    // randomized tuning words and enables
    repeat (4) begin
      settle();
      ch_enable = NCH'($urandom_range(0, (1 << NCH) - 1));
      for (int i = 0; i < NCH; i++) rtw[i*PHASE_W +: PHASE_W] = PHASE_W'($urandom);
      load_tw(rtw);
      run_periods(2);
    end

    // asynchronous reset in the middle of a period
    repeat (500) @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("midrst_aud_pwm", longint'(AUD_PWM), 0);
    check("midrst_aud_sd", longint'(AUD_SD), 0);
    check("midrst_magnitude", longint'(magnitude), MIDV);
    check("midrst_lut_addr", longint'(lut_addr), 0);
    check("midrst_strobe", longint'(sample_strobe), 0);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    run_periods(2);

    repeat (4) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
